// File: rtl/shift_reg_ctrl_if.sv
// Handshake/serial bundle for shift_reg_ctrl. The parity_err signal exists only
// when SHIFT_REG_CTRL_PARITY_EN is defined.
interface shift_reg_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             abort;
  logic             SI;
  logic             SO;
  logic             sh_en;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;
`ifdef SHIFT_REG_CTRL_PARITY_EN
  logic             parity_err;

  modport master (
    output tx_data, tx_valid, abort, SI,
    input  tx_ready, SO, sh_en, rx_data, rx_valid, busy, parity_err
  );
  modport slave (
    input  tx_data, tx_valid, abort, SI,
    output tx_ready, SO, sh_en, rx_data, rx_valid, busy, parity_err
  );
`else
  modport master (
    output tx_data, tx_valid, abort, SI,
    input  tx_ready, SO, sh_en, rx_data, rx_valid, busy
  );
  modport slave (
    input  tx_data, tx_valid, abort, SI,
    output tx_ready, SO, sh_en, rx_data, rx_valid, busy
  );
`endif
endinterface

// File: rtl/shift_reg_ctrl.sv
// Full-duplex serializer/deserializer controller: one word out on SO, one in on SI,
// DIV clocks per bit. Optional even-parity bit enabled by SHIFT_REG_CTRL_PARITY_EN.
module shift_reg_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic           clk,
  input  logic           rst,
  shift_reg_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(DIV);

`ifdef SHIFT_REG_CTRL_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             so_q, so_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             sh_en;
  logic             last_div;
  logic [WIDTH-1:0] shift_in;
`ifdef SHIFT_REG_CTRL_PARITY_EN
  logic             par_q, par_d;
  logic             par_si_q, par_si_d;
  logic             perr_q, perr_d;
`endif

  assign last_div = (div_cnt_q == DW'(DIV - 1));
  // SI enters at the end vacated by the bit just presented on SO.
  assign shift_in = (LSB_FIRST != 0) ? {bus.SI, shreg_q[WIDTH-1:1]}
                                     : {shreg_q[WIDTH-2:0], bus.SI};

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sh_en      = 1'b0;
    so_d       = 1'b0;
`ifdef SHIFT_REG_CTRL_PARITY_EN
    par_d      = par_q;
    par_si_d   = par_si_q;
    perr_d     = perr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.tx_valid && !bus.abort) begin
          shreg_d   = bus.tx_data;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT;
`ifdef SHIFT_REG_CTRL_PARITY_EN
          par_d     = ^bus.tx_data;
`endif
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (last_div) begin
          sh_en     = 1'b1;
          shreg_d   = shift_in;
          bit_cnt_d = bit_cnt_q + CW'(1);
          div_cnt_d = '0;
          if (bit_cnt_q == CW'(WIDTH - 1)) begin
`ifdef SHIFT_REG_CTRL_PARITY_EN
            state_d = PARITY;
`else
            state_d = DONE;
`endif
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
`ifdef SHIFT_REG_CTRL_PARITY_EN
      PARITY: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (last_div) begin
          sh_en     = 1'b1;
          par_si_d  = bus.SI;
          div_cnt_d = '0;
          state_d   = DONE;
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
        if (!bus.abort) begin
          rx_data_d  = shreg_q;
          rx_valid_d = 1'b1;
`ifdef SHIFT_REG_CTRL_PARITY_EN
          perr_d     = (par_si_q != ^shreg_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // SO is registered, so it is computed from the state being entered.
    if (state_d == SHIFT)
      so_d = (LSB_FIRST != 0) ? shreg_d[0] : shreg_d[WIDTH-1];
`ifdef SHIFT_REG_CTRL_PARITY_EN
    if (state_d == PARITY)
      so_d = par_d;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      so_q       <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      so_q       <= so_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

`ifdef SHIFT_REG_CTRL_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q    <= 1'b0;
      par_si_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      par_q    <= par_d;
      par_si_q <= par_si_d;
      perr_q   <= perr_d;
    end
  end

  assign bus.parity_err = perr_q;
`endif

  assign bus.tx_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.SO       = so_q;
  assign bus.sh_en    = sh_en;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  a_bit_cnt_max: assert property (@(posedge clk) disable iff (rst)
    bit_cnt_q <= CW'(WIDTH));
  a_sh_en_busy: assert property (@(posedge clk) disable iff (rst)
    sh_en |-> (state_q != IDLE));
  a_rx_valid_pulse: assert property (@(posedge clk) disable iff (rst)
    rx_valid_q |=> !rx_valid_q);
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Self-checking bench for shift_reg_ctrl (WIDTH=8, DIV=4, MSB first): vector table
// plus hand sequences for abort, back-to-back, mid-transfer reset and parity.
module tb_shift_reg_ctrl;
  localparam int WIDTH = 8;
  localparam int DIV   = 4;
`ifdef SHIFT_REG_CTRL_PARITY_EN
  localparam int LAT = (WIDTH + 1) * DIV + 1;
  localparam int NSH = WIDTH + 1;
`else
  localparam int LAT = WIDTH * DIV + 1;
  localparam int NSH = WIDTH;
`endif
  localparam logic [15:0] SO_MASK = 16'((1 << NSH) - 1);

  typedef struct {
    logic [7:0] data;
    int         acc;
  } sb_t;

  typedef struct {
    logic [7:0] tx;
    logic [1:0] mode;    // 0: SI=0, 1: SI=1, 2: SI looped from SO
    logic [7:0] exp_rx;
    logic [7:0] exp_so;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] si_mode = 2'd0;
  logic [7:0] exp_next = 8'h00;
  logic [7:0] last_rx = 8'h00;

  int nchk = 0, nfail = 0;
  int cyc = 0;
  int acc_cnt = 0, rx_cnt = 0, sh_cnt = 0, last_sh = 0;
  int acc_prev = 0, acc_last = 0;
  logic        sh_bad = 1'b0;
  logic [15:0] so_bits = '0;
  sb_t sb[$];
  vec_t vecs[6];

  shift_reg_ctrl_if #(.WIDTH(WIDTH)) bus();

  shift_reg_ctrl #(.WIDTH(WIDTH), .DIV(DIV), .LSB_FIRST(0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  assign bus.SI = (si_mode == 2'd2) ? bus.SO : si_mode[0];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_valid && bus.tx_ready && !bus.abort) begin
        sb.push_back('{exp_next, cyc + 1});
        acc_cnt++;
        acc_prev = acc_last;
        acc_last = cyc + 1;
        sh_cnt   = 0;
        sh_bad   = 1'b0;
        so_bits  = '0;
      end
      if (bus.sh_en) begin
        if (sh_cnt > 0 && (cyc - last_sh) != DIV) sh_bad = 1'b1;
        last_sh = cyc;
        sh_cnt++;
        so_bits = {so_bits[14:0], bus.SO};
      end
      if (bus.rx_valid) begin
        rx_cnt++;
        chk("rx_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          sb_t e;
          e = sb.pop_front();
          chk("rx_data", 32'(bus.rx_data), 32'(e.data));
          chk("rx_latency", 32'(cyc - e.acc), 32'(LAT));
          last_rx = e.data;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_acc(input int n);
    int i = 0;
    while (acc_cnt < n && i < 200) begin tick(); i++; end
    chk("accept_timeout", 32'(acc_cnt >= n), 32'd1);
  endtask

  task automatic wait_rx(input int n);
    int i = 0;
    while (rx_cnt < n && i < 200) begin tick(); i++; end
    chk("rx_timeout", 32'(rx_cnt >= n), 32'd1);
  endtask

  task automatic wait_sh(input int n);
    int i = 0;
    while (sh_cnt < n && i < 200) begin tick(); i++; end
    chk("sh_en_timeout", 32'(sh_cnt >= n), 32'd1);
  endtask

  task automatic run_vec(input logic [7:0] d, input logic [1:0] mode,
                         input logic [7:0] exp_rx, input logic [7:0] exp_so);
    int a0, r0;
    logic [15:0] so_exp;
    a0 = acc_cnt;
    r0 = rx_cnt;
`ifdef SHIFT_REG_CTRL_PARITY_EN
    so_exp = {7'b0, exp_so, ^d};
`else
    so_exp = {8'b0, exp_so};
`endif
    si_mode      = mode;
    bus.tx_data  = d;
    exp_next     = exp_rx;
    bus.tx_valid = 1'b1;
    wait_acc(a0 + 1);
    bus.tx_valid = 1'b0;
    wait_rx(r0 + 1);
    chk("sh_en_count", 32'(sh_cnt), 32'(NSH));
    chk("sh_en_spacing", 32'(sh_bad), 32'd0);
    chk("so_sequence", 32'(so_bits & SO_MASK), 32'(so_exp));
`ifdef SHIFT_REG_CTRL_PARITY_EN
    begin
      logic par_si;
      par_si = (mode == 2'd2) ? ^d : mode[0];
      chk("parity_err", 32'(bus.parity_err), 32'(par_si ^ (^exp_rx)));
    end
`endif
  endtask

  initial begin
    int a0, r0;
    vecs[0] = '{8'hA5, 2'd2, 8'hA5, 8'hA5};
    vecs[1] = '{8'h00, 2'd1, 8'hFF, 8'h00};
    vecs[2] = '{8'hFF, 2'd0, 8'h00, 8'hFF};
    vecs[3] = '{8'h3C, 2'd2, 8'h3C, 8'h3C};
    vecs[4] = '{8'h81, 2'd1, 8'hFF, 8'h81};
    vecs[5] = '{8'h07, 2'd2, 8'h07, 8'h07};

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.abort    = 1'b0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_SO", 32'(bus.SO), 32'd0);
    chk("rst_sh_en", 32'(bus.sh_en), 32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_tx_ready", 32'(bus.tx_ready), 32'd1);
    tick();

    foreach (vecs[i]) run_vec(vecs[i].tx, vecs[i].mode, vecs[i].exp_rx, vecs[i].exp_so);

    // Abort after the 3rd sh_en, then abort+tx_valid together in IDLE.
    a0 = acc_cnt;
    si_mode = 2'd2; bus.tx_data = 8'h3C; exp_next = 8'h3C; bus.tx_valid = 1'b1;
    wait_acc(a0 + 1);
    bus.tx_valid = 1'b0;
    wait_sh(3);
    r0 = rx_cnt;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("abort_SO", 32'(bus.SO), 32'd0);
    tick();
    a0 = acc_cnt;
    bus.tx_valid = 1'b1; bus.abort = 1'b1; bus.tx_data = 8'h99;
    tick();
    bus.tx_valid = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_wins_busy", 32'(bus.busy), 32'd0);
    chk("abort_wins_noacc", 32'(acc_cnt), 32'(a0));
    repeat (LAT + 5) tick();
    chk("abort_no_rx_valid", 32'(rx_cnt), 32'(r0));
    chk("abort_rx_hold", 32'(bus.rx_data), 32'(last_rx));

    // Back-to-back with tx_valid held; tx_data changed mid-transfer.
    a0 = acc_cnt; r0 = rx_cnt;
    si_mode = 2'd2; bus.tx_data = 8'h12; exp_next = 8'h12; bus.tx_valid = 1'b1;
    wait_acc(a0 + 1);
    bus.tx_data = 8'h34; exp_next = 8'h34;
    wait_acc(a0 + 2);
    bus.tx_valid = 1'b0;
    chk("b2b_gap", 32'(acc_last - acc_prev), 32'(LAT + 1));
    wait_rx(r0 + 2);

    // Reset after the 5th sh_en; no accept while rst is high.
    a0 = acc_cnt;
    si_mode = 2'd2; bus.tx_data = 8'hC3; exp_next = 8'hC3; bus.tx_valid = 1'b1;
    wait_acc(a0 + 1);
    bus.tx_valid = 1'b0;
    wait_sh(5);
    rst = 1'b1;
    sb.delete();
    r0 = rx_cnt;
    a0 = acc_cnt;
    bus.tx_valid = 1'b1; bus.tx_data = 8'h99;
    @(negedge clk);
    chk("mrst_SO", 32'(bus.SO), 32'd0);
    chk("mrst_sh_en", 32'(bus.sh_en), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("mrst_rx_data", 32'(bus.rx_data), 32'd0);
    tick();
    @(negedge clk);
    chk("mrst_no_accept", 32'(bus.busy), 32'd0);
    tick();
    bus.tx_valid = 1'b0;
    rst = 1'b0;
    last_rx = 8'h00;
    @(negedge clk);
    chk("mrst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("mrst_no_rx", 32'(rx_cnt), 32'(r0));
    chk("mrst_acc", 32'(acc_cnt), 32'(a0));
    tick();
    run_vec(8'h5A, 2'd2, 8'h5A, 8'h5A);

`ifdef SHIFT_REG_CTRL_PARITY_EN
    // Loop data bits but force SI low during the parity bit.
    a0 = acc_cnt; r0 = rx_cnt;
    si_mode = 2'd2; bus.tx_data = 8'h07; exp_next = 8'h07; bus.tx_valid = 1'b1;
    wait_acc(a0 + 1);
    bus.tx_valid = 1'b0;
    wait_sh(WIDTH);
    si_mode = 2'd0;
    wait_rx(r0 + 1);
    chk("parity_err_forced", 32'(bus.parity_err), 32'd1);
    repeat (3) tick();
    chk("parity_err_hold", 32'(bus.parity_err), 32'd1);
`endif

    repeat (4) tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
